alu_shift_seq: RTL and testbench

//  Multi-cycle shift sequencer around the existing 4-bit-amount left shifter (alu_sll_8bit).

---
 rtl/alu_shift_seq_pkg.sv | 18 +
 rtl/alu_sll_8bit.sv | 15 +
 rtl/alu_shift_seq.sv | 111 +++++++++++
 tb/tb_alu_shift_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_seq_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: FSM encodings,
// operation codes and the per-pass shift limit of the shared shifter.
package alu_shift_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic        OP_SLL   = 1'b0;
  localparam logic        OP_SRL   = 1'b1;

  // Width of the shared shifter's amount input and the largest pass it can do.
  localparam int          STEP_W   = 4;
  localparam logic [3:0]  STEP_MAX = 4'd15;

endpackage

// File: rtl/alu_sll_8bit.sv
// Combinational left shifter with a 4-bit shift amount (0..15), zero fill.
module alu_sll_8bit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [3:0]   s,
  output logic [N-1:0] z
);

  // Single logical left shift by the 4-bit amount.
  always_comb begin
    z = a << s;
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle SLL/SRL sequencer. Amounts wider than the shifter's 4-bit input
// are split into passes of at most 15 through one shared left shifter; SRL is
// done by bit-reversing the operand on the way in and the result on the way out.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a request, in_ready=1
// S_SHIFT | one shifter pass per cycle until remaining amount <= 15
// S_DONE  | result presented with out_valid=1 until out_ready
module alu_shift_seq
  import alu_shift_seq_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_op,
  input  logic [N-1:0]   in_a,
  input  logic [SHW-1:0] in_amt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic           busy
);

  state_t              state;
  logic [N-1:0]        acc;
  logic [SHW-1:0]      rem;
  logic                op_r;
  logic [STEP_W-1:0]   step;
  logic [N-1:0]        shift_z;
  logic [N-1:0]        a_rev;
  logic [N-1:0]        acc_rev;
  logic                last_pass;

  // Bit reversal of the incoming operand and of the accumulator.
  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_rev
      assign a_rev[i]   = in_a[N-1-i];
      assign acc_rev[i] = acc[N-1-i];
    end
  endgenerate

  // Pass size is the remaining amount clipped to what the shifter can do.
  always_comb begin
    step      = rem[STEP_W-1:0];
    last_pass = 1'b1;
    if (rem > SHW'(STEP_MAX)) begin
      step      = STEP_MAX;
      last_pass = 1'b0;
    end
  end

  alu_sll_8bit #(.N(N)) u_sll (
    .a (acc),
    .s (step),
    .z (shift_z)
  );

  // Sequencer FSM; clr overrides every transition including handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      rem   <= '0;
      op_r  <= 1'b0;
    end else if (clr) begin
      state <= S_IDLE;
      acc   <= '0;
      rem   <= '0;
      op_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            acc   <= (in_op == OP_SRL) ? a_rev : in_a;
            op_r  <= in_op;
            rem   <= in_amt;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc <= shift_z;
          rem <= rem - SHW'(step);
          if (last_pass) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_data  = (op_r == OP_SRL) ? acc_rev : acc;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: directed vector table, random ops
// against a plain-arithmetic reference, and hand-written corner sequences.
module tb_alu_shift_seq;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_a;
  logic [5:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_shift_seq #(.N(32), .SHW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [5:0]  amt;
    logic [31:0] exp_d;
    int          exp_p;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] a, input int amt);
    if (amt >= 32) return 32'h0;
    return op ? (a >> amt) : (a << amt);
  endfunction

  function automatic int ref_passes(input int amt);
    if (amt == 0) return 1;
    return (amt + 14) / 15;
  endfunction

  // Launch one op, measure accept-to-out_valid latency, check data, then drain.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [5:0] amt,
                        input logic [31:0] exp_d, input int exp_p, input string nm);
    int  lat;
    bit  seen;
    @(negedge clk);
    in_op    = op;
    in_a     = a;
    in_amt   = amt;
    in_valid = 1'b1;
    check({nm, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 1'($urandom_range(0, 1));
    in_a     = $urandom;
    in_amt   = 6'($urandom_range(0, 63));
    lat  = -1;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        lat  = k + 1;
      end
    end
    check({nm, " latency"}, 64'(lat), 64'(exp_p));
    check({nm, " data"}, 64'(out_data), 64'(exp_d));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({nm, " drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic        r_op;
    logic [31:0] r_a;
    int          r_amt;
    bit          seen;

    vecs[0] = '{1'b0, 32'h0000_0001, 6'd4,  32'h0000_0010, 1};
    vecs[1] = '{1'b0, 32'h0000_0001, 6'd31, 32'h8000_0000, 3};
    vecs[2] = '{1'b1, 32'h8000_0000, 6'd20, 32'h0000_0800, 2};
    vecs[3] = '{1'b0, 32'hDEAD_BEEF, 6'd0,  32'hDEAD_BEEF, 1};
    vecs[4] = '{1'b1, 32'hDEAD_BEEF, 6'd0,  32'hDEAD_BEEF, 1};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 6'd40, 32'h0000_0000, 3};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF, 6'd63, 32'h0000_0000, 5};
    vecs[7] = '{1'b0, 32'h0000_0001, 6'd15, 32'h0000_8000, 1};
    vecs[8] = '{1'b0, 32'h0000_0001, 6'd16, 32'h0001_0000, 2};
    vecs[9] = '{1'b1, 32'hFFFF_FFFF, 6'd30, 32'h0000_0003, 2};

    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_amt    = '0;
    out_ready = 1'b0;
    #23;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data",  64'(out_data),  64'd0);
    check("reset busy",      64'(busy),      64'd0);
    check("reset in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].op, vecs[v].a, vecs[v].amt, vecs[v].exp_d, vecs[v].exp_p,
             $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 40; r++) begin
      r_op  = 1'($urandom_range(0, 1));
      r_a   = $urandom;
      r_amt = $urandom_range(0, 63);
      run_op(r_op, r_a, 6'(r_amt), ref_shift(r_op, r_a, r_amt), ref_passes(r_amt),
             $sformatf("rnd%0d", r));
    end

    // Backpressure: result held while producer keeps pushing.
    @(negedge clk);
    in_op = 1'b0; in_a = 32'h5; in_amt = 6'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_a = 32'h1; in_amt = 6'd2; in_op = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("bp valid", 64'(out_valid), 64'd1);
    held = out_data;
    check("bp data", 64'(held), 64'h28);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp hold valid", 64'(out_valid), 64'd1);
      check("bp hold data", 64'(out_data), 64'h28);
      check("bp hold in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp released valid", 64'(out_valid), 64'd0);
    check("bp released busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp next accepted", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check("bp next valid", 64'(out_valid), 64'd1);
    check("bp next data", 64'(out_data), 64'h4);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Abort during SHIFT of a 3-pass op.
    @(negedge clk);
    in_op = 1'b0; in_a = 32'hFFFF_FFFF; in_amt = 6'd45; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr busy", 64'(busy), 64'd0);
    check("clr data", 64'(out_data), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("clr no valid", 64'(seen), 64'd0);

    // Handshake coinciding with clr is dropped.
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_a = 32'h1; in_amt = 6'd1;
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    check("clr drops accept", 64'(busy), 64'd0);

    // Reset mid-SHIFT returns outputs immediately.
    @(negedge clk);
    in_op = 1'b1; in_a = 32'h8000_0000; in_amt = 6'd63; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'h3, 6'd1, 32'h6, 1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
